// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the iterative multiplier.
// Holds operand-mode encodings, FSM states and the accumulator sizing helper.
package mul_pkg;

  localparam logic MUL_UNSIGNED = 1'b0;
  localparam logic MUL_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // High part of the accumulator: one guard bit beyond the worst-case STEP-bit partial sum.
  function automatic int acc_width(input int n_bit, input int step);
    return n_bit + step + 1;
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Operand and result handshake bundle for seq_mul.
// The master drives operands and result acceptance; the slave is the multiplier.
interface seq_mul_if #(
  parameter int N_BIT = 4
) ();
  localparam int RES_SIZE = N_BIT * 2;

  logic                in_valid;
  logic                in_ready;
  logic [N_BIT-1:0]    A;
  logic [N_BIT-1:0]    B;
  logic                mul_type;
  logic                out_valid;
  logic                out_ready;
  logic [RES_SIZE-1:0] product;

  modport master (
    output in_valid, A, B, mul_type, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, A, B, mul_type, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_mul_step.sv
// One iteration of the shift-add multiplier: adds STEP weighted partial products
// into the high accumulator, then shifts the whole {high, multiplier} word right.
module mul_step
  import mul_pkg::*;
#(
  parameter  int N_BIT = 4,
  parameter  int STEP  = 1,
  localparam int W_HI  = acc_width(N_BIT, STEP),
  localparam int W_ACC = W_HI + N_BIT
) (
  input  logic [W_ACC-1:0] acc_i,
  input  logic [N_BIT-1:0] a_i,
  input  logic [STEP-1:0]  bits_i,
  input  logic             mul_type_i,
  input  logic             last_i,
  output logic [W_ACC-1:0] acc_o
);

  logic [W_HI-1:0]         ext;
  logic [W_HI-1:0]         sum;
  logic signed [W_ACC-1:0] joined;

  always_comb begin
    ext = '0;
    sum = '0;
    joined = '0;
    if (mul_type_i == MUL_SIGNED)
      ext = {{(W_HI-N_BIT){a_i[N_BIT-1]}}, a_i};
    else
      ext = {{(W_HI-N_BIT){1'b0}}, a_i};
    sum = acc_i[W_ACC-1:N_BIT];
    for (int i = 0; i < STEP; i++) begin
      if (bits_i[i]) begin
        // Multiplier MSB carries weight -2^(N_BIT-1) in signed mode.
        if (last_i && (mul_type_i == MUL_SIGNED) && (i == STEP-1))
          sum = sum - (ext << i);
        else
          sum = sum + (ext << i);
      end
    end
    joined = {sum, acc_i[N_BIT-1:0]};
    acc_o  = joined >>> STEP;
  end

endmodule

// File: rtl/seq_mul.sv
// Iterative signed/unsigned multiplier retiring STEP multiplier bits per clock,
// with valid/ready handshakes on operands and result.
module seq_mul
  import mul_pkg::*;
#(
  parameter int N_BIT = 4,
  parameter int STEP  = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  output logic      busy,
  seq_mul_if.slave  bus
);

  localparam int RES_SIZE = N_BIT * 2;
  localparam int W_HI     = acc_width(N_BIT, STEP);
  localparam int W_ACC    = W_HI + N_BIT;
  localparam int N_ITER   = N_BIT / STEP;
  localparam int CNT_W    = $clog2(N_ITER) + 1;

  mul_state_t          state_q;
  logic [W_ACC-1:0]    acc_q, acc_d;
  logic [N_BIT-1:0]    a_q;
  logic                mt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                in_ready_q, out_valid_q, busy_q;
  logic [RES_SIZE-1:0] product_q, product_d;
  logic                last;

  assign last      = (cnt_q == CNT_W'(N_ITER - 1));
  assign product_d = acc_d[RES_SIZE-1:0];

  mul_step #(.N_BIT(N_BIT), .STEP(STEP)) u_step (
    .acc_i      (acc_q),
    .a_i        (a_q),
    .bits_i     (acc_q[STEP-1:0]),
    .mul_type_i (mt_q),
    .last_i     (last),
    .acc_o      (acc_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      mt_q        <= MUL_UNSIGNED;
      cnt_q       <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.A;
            mt_q       <= bus.mul_type;
            acc_q      <= {{W_HI{1'b0}}, bus.B};
            cnt_q      <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            product_q   <= product_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;
  assign busy          = busy_q;

endmodule
